rr_stream_mux: RTL and testbench
================================

Name: rr_stream_mux

Overview:
- Parametrised successor to the team's static select-driven N:1 mux.
- Selects among N valid/ready input streams with a built-in arbiter (round-robin or fixed-priority) instead of an external select.
- Holds the grant for a whole packet, delimited by last, and drives one registered output stage.
- Sits between multiple producers (DMA channels, request queues) and a single shared consumer bus.

Parameters:
- WIDTH, 32, data bits per beat.
- N, 4, number of input channels; legal range 2..16.
- ARB_MODE, ARB_RR, arbitration policy from rr_mux_pkg: ARB_RR (round-robin) or ARB_FIXED (lowest index wins).
- PKT_LOCK, 1, 1 = hold grant until a last beat transfers; 0 = re-arbitrate every beat.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  N  per-channel beat valid.
- in_data  input  N x WIDTH  per-channel data, packed array [N-1:0][WIDTH-1:0].
- in_last  input  N  per-channel end-of-packet flag.
- in_ready  output  N  per-channel accept; at most one bit high.
- out_valid  output  1  registered output valid.
- out_data  output  WIDTH  registered output data.
- out_last  output  1  registered end-of-packet.
- out_sel  output  SEL_W  channel index of the beat currently on the output; SEL_W = max(1, $clog2(N)).
- out_ready  input  1  consumer accept.
- locked  output  1  high while a packet is in progress (PKT_LOCK=1 only).

Behaviour:
- Reset (async assert, sync release): out_valid=0, out_data=0, out_last=0, out_sel=0, locked=0, in_ready=0, rr pointer = N-1 so channel 0 has top priority first.
- Transfer rules:
  - An input transfer occurs when in_valid[i] and in_ready[i] are both high.
  - An output transfer occurs when out_valid and out_ready are both high.
- slot_free = !out_valid || out_ready. in_ready is combinational from slot_free, the grant and in_valid, and never from out_data.
- Latency: one cycle from input transfer to out_valid. Full throughput of one beat per clock while out_ready stays high.
- out_valid/out_data/out_last/out_sel hold stable while out_valid=1 and out_ready=0.
- If slot_free is high and no input transfers, out_valid goes to 0 next cycle.
- FSM, two states:
  - UNLOCKED:
    - When slot_free, the arbiter picks among in_valid.
    - ARB_RR: search starts at pointer+1 and wraps N-1 to 0. ARB_FIXED: lowest set index wins.
    - The granted channel gets in_ready; the beat is registered.
    - The rr pointer updates to the granted index only on a transfer.
    - If PKT_LOCK=1 and the transferred beat has in_last=0, go to LOCKED and record the channel.
  - LOCKED:
    - Only the recorded channel may get in_ready; all other channels are stalled even if valid.
    - If the locked channel deasserts in_valid, the output bubbles and the lock holds. No channel switch.
    - A transfer with in_last=1 returns to UNLOCKED, and the pointer updates to the locked channel.
    - locked=1 in this state.
- Single-beat packet (in_last=1 on first beat): no lock entered.
- PKT_LOCK=0: in_last is passed through only; the FSM stays UNLOCKED.
- No valid inputs: in_ready=0; the pointer and FSM state are unchanged.
- Reset mid-packet: lock cleared, output emptied, and the beat in flight is discarded.
- Inputs must not retract in_valid before a transfer. This is a bench assertion, not enforced by RTL.

Decomposition:
- Package rr_mux_pkg holds:
  - the arb_mode_e enum (ARB_RR, ARB_FIXED);
  - the mux_state_e enum (ST_UNLOCKED, ST_LOCKED);
  - a sel_width(N) constant function.
- One sub-module, rr_arbiter:
  - purely combinational;
  - inputs: request vector, pointer, mode; output: one-hot grant plus encoded index;
  - reused by future arbitrated blocks.
- The top level owns the pointer, lock state, output register and handshake.

Test Plan:
- Reset, then all four channels valid with single-beat packets (data 0xA0..0xA3, last=1) and out_ready=1 -> outputs A0, A1, A2, A3, A0 on consecutive cycles; out_sel = 0,1,2,3,0; first out_valid one cycle after the first in_ready.
- ch1 sends a 3-beat packet 0x10, 0x11, 0x12(last) while ch0 and ch2 hold valid -> output 10, 11, 12 contiguous; locked=1 for two cycles; in_ready[0]=in_ready[2]=0 during the packet; next grant goes to ch2.
- out_ready=0 for 3 cycles with out_data=0x55 registered -> out_data stays 0x55, out_valid stays 1, all in_ready=0; on release, the next beat appears the following cycle.
- ARB_FIXED, ch3 and ch1 valid continuously, single beats -> ch1 always wins; ch3 starves and in_ready[3] is never high.
- Locked ch2 drops in_valid for 2 cycles mid-packet while ch0 is valid -> out_valid=0 bubble, locked stays 1, ch0 is not granted; the packet resumes on ch2.
- Assert rst while locked with out_valid=1 -> out_valid=0 and locked=0 immediately (async); after release, channel 0 has first priority.

Source files
------------

// File: rtl/rr_mux_pkg.sv
// Shared types and helpers for the arbitrated stream mux family.
// No logic of its own; zero latency.
// No flow control; types only.
package rr_mux_pkg;

  typedef enum logic {
    ARB_RR    = 1'b0,
    ARB_FIXED = 1'b1
  } arb_mode_e;

  typedef enum logic {
    ST_UNLOCKED = 1'b0,
    ST_LOCKED   = 1'b1
  } mux_state_e;

  // Index width for an N-entry select; never narrower than one bit.
  function automatic int sel_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// N-way request arbiter: round-robin after a pointer, or lowest index first.
// Purely combinational, zero latency.
// No backpressure of its own; the caller qualifies the grant with its slot state.
module rr_arbiter
  import rr_mux_pkg::*;
#(
  parameter int N = 4,
  localparam int SEL_W = sel_width(N)
) (
  input  logic [N-1:0]     req_i,
  input  logic [SEL_W-1:0] ptr_i,
  input  arb_mode_e        mode_i,
  output logic [N-1:0]     gnt_o,
  output logic [SEL_W-1:0] idx_o
);

  int  cand;
  logic found;

  // First requester wins: scan from index 0, or from ptr_i+1 with wrap for round-robin.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    cand  = 0;
    if (mode_i == ARB_FIXED) begin
      for (int i = 0; i < N; i++) begin
        if (!found && req_i[i]) begin
          found    = 1'b1;
          gnt_o[i] = 1'b1;
          idx_o    = SEL_W'(i);
        end
      end
    end else begin
      for (int k = 1; k <= N; k++) begin
        // The pointer always holds a legal index, so one subtraction wraps it.
        cand = int'(ptr_i) + k;
        if (cand >= N) cand = cand - N;
        if (!found && req_i[cand]) begin
          found       = 1'b1;
          gnt_o[cand] = 1'b1;
          idx_o       = SEL_W'(cand);
        end
      end
    end
  end

endmodule

// File: rtl/rr_stream_mux.sv
// Arbitrated N:1 valid/ready stream mux with optional packet locking on last.
// One cycle from input transfer to out_valid; one beat per clock at full rate.
// Output register holds while out_ready is low; in_ready only rises when the slot frees.
module rr_stream_mux
  import rr_mux_pkg::*;
#(
  parameter int        WIDTH    = 32,
  parameter int        N        = 4,
  parameter arb_mode_e ARB_MODE = ARB_RR,
  parameter bit        PKT_LOCK = 1'b1,
  localparam int       SEL_W    = sel_width(N)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N-1:0]              in_valid,
  input  logic [N-1:0][WIDTH-1:0]   in_data,
  input  logic [N-1:0]              in_last,
  output logic [N-1:0]              in_ready,
  output logic                      out_valid,
  output logic [WIDTH-1:0]          out_data,
  output logic                      out_last,
  output logic [SEL_W-1:0]          out_sel,
  input  logic                      out_ready,
  output logic                      locked
);

  mux_state_e       state_q, state_d;
  logic [SEL_W-1:0] lock_ch_q, lock_ch_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_last_q, out_last_d;
  logic [SEL_W-1:0] out_sel_q, out_sel_d;

  logic             slot_free;
  logic [N-1:0]     lock_mask;
  logic [N-1:0]     arb_req;
  logic [N-1:0]     gnt;
  logic [SEL_W-1:0] gnt_idx;
  logic             xfer;
  logic             beat_last;

  // While a packet is in flight only the owning channel may compete.
  always_comb begin
    lock_mask            = '0;
    lock_mask[lock_ch_q] = 1'b1;
    arb_req              = (state_q == ST_LOCKED) ? (in_valid & lock_mask) : in_valid;
  end

  rr_arbiter #(
    .N(N)
  ) u_arb (
    .req_i  (arb_req),
    .ptr_i  (ptr_q),
    .mode_i (ARB_MODE),
    .gnt_o  (gnt),
    .idx_o  (gnt_idx)
  );

  // Handshake: accept only when the output slot is free; nothing is accepted during reset.
  always_comb begin
    slot_free = !out_valid_q || out_ready;
    in_ready  = (slot_free && !rst) ? gnt : '0;
    xfer      = |(in_valid & in_ready);
    beat_last = in_last[gnt_idx];
  end

  // Next-state: output stage load, pointer advance and packet lock tracking.
  always_comb begin
    state_d     = state_q;
    lock_ch_d   = lock_ch_q;
    ptr_d       = ptr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    out_sel_d   = out_sel_q;

    if (slot_free) begin
      out_valid_d = xfer;
      if (xfer) begin
        out_data_d = in_data[gnt_idx];
        out_last_d = beat_last;
        out_sel_d  = gnt_idx;
      end
    end

    if (xfer) begin
      // In the locked state gnt_idx is the locked channel, so this covers both cases.
      ptr_d = gnt_idx;
      case (state_q)
        ST_UNLOCKED: begin
          if (PKT_LOCK && !beat_last) begin
            state_d   = ST_LOCKED;
            lock_ch_d = gnt_idx;
          end
        end
        ST_LOCKED: begin
          if (beat_last) state_d = ST_UNLOCKED;
        end
        default: state_d = ST_UNLOCKED;
      endcase
    end
  end

  // State registers; reset parks the pointer on N-1 so channel 0 is served first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_UNLOCKED;
      lock_ch_q   <= '0;
      ptr_q       <= SEL_W'(N - 1);
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_sel_q   <= '0;
    end else begin
      state_q     <= state_d;
      lock_ch_q   <= lock_ch_d;
      ptr_q       <= ptr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      out_sel_q   <= out_sel_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign out_sel   = out_sel_q;
  assign locked    = (state_q == ST_LOCKED);

endmodule

// File: tb/tb_rr_stream_mux.sv
// Bench for rr_stream_mux: vector tables, directed corner sequences, random run vs model.
// Checks are taken on the falling edge; inputs change 1 time unit after the rising edge.
// Random sources obey valid/ready: a raised valid is held until it is accepted.
module tb_rr_stream_mux;
  import rr_mux_pkg::*;

  localparam int N  = 4;
  localparam int W  = 32;
  localparam int SW = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Round-robin DUT signals
  logic [N-1:0]        in_valid, in_last, in_ready;
  logic [N-1:0][W-1:0] in_data;
  logic                out_valid, out_last, out_ready, locked;
  logic [W-1:0]        out_data;
  logic [SW-1:0]       out_sel;

  // Fixed-priority DUT signals
  logic [N-1:0]        f_in_valid, f_in_last, f_in_ready;
  logic [N-1:0][W-1:0] f_in_data;
  logic                f_out_valid, f_out_last, f_out_ready, f_locked;
  logic [W-1:0]        f_out_data;
  logic [SW-1:0]       f_out_sel;

  rr_stream_mux #(.WIDTH(W), .N(N), .ARB_MODE(ARB_RR), .PKT_LOCK(1'b1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
    .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
    .out_sel(out_sel), .out_ready(out_ready), .locked(locked)
  );

  rr_stream_mux #(.WIDTH(W), .N(N), .ARB_MODE(ARB_FIXED), .PKT_LOCK(1'b1)) dut_fixed (
    .clk(clk), .rst(rst), .in_valid(f_in_valid), .in_data(f_in_data), .in_last(f_in_last),
    .in_ready(f_in_ready), .out_valid(f_out_valid), .out_data(f_out_data), .out_last(f_out_last),
    .out_sel(f_out_sel), .out_ready(f_out_ready), .locked(f_locked)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Source protocol: a beat offered and not accepted must still be offered next cycle.
  logic [N-1:0] pend_q;
  always @(posedge clk) begin
    if (rst) begin
      pend_q <= '0;
    end else begin
      checks++;
      if ((pend_q & ~in_valid) != '0) begin
        errors++;
        $display("FAIL valid_retract: valid %b, pending %b", in_valid, pend_q);
      end
      pend_q <= in_valid & ~in_ready;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    bit                  rst_before;
    logic [N-1:0]        v;
    logic [N-1:0]        l;
    logic [N-1:0][W-1:0] d;
    logic                ordy;
    logic [N-1:0]        e_ir;
    logic                e_ov;
    logic [W-1:0]        e_od;
    logic                e_ol;
    logic [SW-1:0]       e_os;
    logic                e_lk;
  } vec_t;

  function automatic vec_t mk(input int r, input logic [3:0] v, input logic [3:0] l,
                              input logic [31:0] d3, input logic [31:0] d2,
                              input logic [31:0] d1, input logic [31:0] d0,
                              input int ordy, input logic [3:0] ir, input int ov,
                              input logic [31:0] od, input int ol, input int os, input int lk);
    vec_t t;
    t.rst_before = (r != 0);
    t.v    = v;
    t.l    = l;
    t.d    = {d3, d2, d1, d0};
    t.ordy = (ordy != 0);
    t.e_ir = ir;
    t.e_ov = (ov != 0);
    t.e_od = od;
    t.e_ol = (ol != 0);
    t.e_os = SW'(os);
    t.e_lk = (lk != 0);
    return t;
  endfunction

  task automatic do_reset();
    rst         = 1'b1;
    in_valid    = '0;
    in_last     = '0;
    in_data     = '0;
    out_ready   = 1'b1;
    f_in_valid  = '0;
    f_in_last   = '0;
    f_in_data   = '0;
    f_out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic apply(input vec_t t, input string nm);
    if (t.rst_before) do_reset();
    @(posedge clk);
    #1;
    in_valid  = t.v;
    in_last   = t.l;
    in_data   = t.d;
    out_ready = t.ordy;
    @(negedge clk);
    chk({nm, ".in_ready"}, 32'(in_ready), 32'(t.e_ir));
    chk({nm, ".out_valid"}, 32'(out_valid), 32'(t.e_ov));
    chk({nm, ".locked"}, 32'(locked), 32'(t.e_lk));
    if (t.e_ov) begin
      chk({nm, ".out_data"}, out_data, t.e_od);
      chk({nm, ".out_last"}, 32'(out_last), 32'(t.e_ol));
      chk({nm, ".out_sel"}, 32'(out_sel), 32'(t.e_os));
    end
  endtask

  task automatic run_random(input int cycles);
    int  m_ptr, m_lock, m_os, g;
    bit  m_ov, m_ol, free;
    logic [31:0] m_od;
    logic [N-1:0] exp_ir;
    do_reset();
    m_ptr = N - 1; m_lock = -1; m_ov = 0; m_ol = 0; m_od = 0; m_os = 0;
    for (int ch = 0; ch < N; ch++) begin
      in_valid[ch] = ($urandom_range(0, 1) == 1);
      in_data[ch]  = $urandom;
      in_last[ch]  = ($urandom_range(0, 2) == 0);
    end
    out_ready = 1'b1;
    for (int cyc = 0; cyc < cycles; cyc++) begin
      @(negedge clk);
      free = !m_ov || out_ready;
      g = -1;
      if (free) begin
        if (m_lock >= 0) begin
          if (in_valid[m_lock]) g = m_lock;
        end else begin
          for (int k = 1; k <= N; k++) begin
            int c;
            c = (m_ptr + k) % N;
            if (g < 0 && in_valid[c]) g = c;
          end
        end
      end
      exp_ir = (g >= 0) ? (N'(1) << g) : '0;
      chk("rnd.in_ready", 32'(in_ready), 32'(exp_ir));
      chk("rnd.out_valid", 32'(out_valid), 32'(m_ov));
      chk("rnd.locked", 32'(locked), 32'(m_lock >= 0));
      if (m_ov) begin
        chk("rnd.out_data", out_data, m_od);
        chk("rnd.out_last", 32'(out_last), 32'(m_ol));
        chk("rnd.out_sel", 32'(out_sel), 32'(m_os));
      end
      if (free) begin
        m_ov = (g >= 0);
        if (g >= 0) begin
          m_od   = in_data[g];
          m_ol   = in_last[g];
          m_os   = g;
          m_ptr  = g;
          m_lock = in_last[g] ? -1 : g;
        end
      end
      @(posedge clk);
      #1;
      for (int ch = 0; ch < N; ch++) begin
        if (!in_valid[ch] || g == ch) begin
          if ($urandom_range(0, 9) < 6) begin
            in_valid[ch] = 1'b1;
            in_data[ch]  = $urandom;
            in_last[ch]  = ($urandom_range(0, 2) == 0);
          end else begin
            in_valid[ch] = 1'b0;
          end
        end
      end
      out_ready = ($urandom_range(0, 3) != 0);
    end
  endtask

  vec_t tbl[$];

  initial begin
    // Reset state, with every channel requesting to prove in_ready is held low.
    rst         = 1'b1;
    in_valid    = '1;
    in_last     = '1;
    in_data     = '0;
    out_ready   = 1'b1;
    f_in_valid  = '0;
    f_in_last   = '0;
    f_in_data   = '0;
    f_out_ready = 1'b1;
    @(negedge clk);
    chk("reset.in_ready", 32'(in_ready), 32'h0);
    chk("reset.out_valid", 32'(out_valid), 32'h0);
    chk("reset.out_data", out_data, 32'h0);
    chk("reset.out_last", 32'(out_last), 32'h0);
    chk("reset.out_sel", 32'(out_sel), 32'h0);
    chk("reset.locked", 32'(locked), 32'h0);

    // Round-robin over four single-beat channels
    tbl.push_back(mk(1, 4'b1111, 4'b1111, 'hA3, 'hA2, 'hA1, 'hA0, 1, 4'b0001, 0, 'h0, 0, 0, 0));
    tbl.push_back(mk(0, 4'b1111, 4'b1111, 'hA3, 'hA2, 'hA1, 'hA0, 1, 4'b0010, 1, 'hA0, 1, 0, 0));
    tbl.push_back(mk(0, 4'b1111, 4'b1111, 'hA3, 'hA2, 'hA1, 'hA0, 1, 4'b0100, 1, 'hA1, 1, 1, 0));
    tbl.push_back(mk(0, 4'b1111, 4'b1111, 'hA3, 'hA2, 'hA1, 'hA0, 1, 4'b1000, 1, 'hA2, 1, 2, 0));
    tbl.push_back(mk(0, 4'b1111, 4'b1111, 'hA3, 'hA2, 'hA1, 'hA0, 1, 4'b0001, 1, 'hA3, 1, 3, 0));
    tbl.push_back(mk(0, 4'b1111, 4'b1111, 'hA3, 'hA2, 'hA1, 'hA0, 1, 4'b0010, 1, 'hA0, 1, 0, 0));
    // ch1 three-beat packet while ch0 and ch2 wait; ch2 is served next
    tbl.push_back(mk(1, 4'b0001, 4'b0001, 'h0, 'h0, 'h0, 'h01, 1, 4'b0001, 0, 'h0, 0, 0, 0));
    tbl.push_back(mk(0, 4'b0111, 4'b0101, 'h0, 'h20, 'h10, 'h02, 1, 4'b0010, 1, 'h01, 1, 0, 0));
    tbl.push_back(mk(0, 4'b0111, 4'b0101, 'h0, 'h20, 'h11, 'h02, 1, 4'b0010, 1, 'h10, 0, 1, 1));
    tbl.push_back(mk(0, 4'b0111, 4'b0111, 'h0, 'h20, 'h12, 'h02, 1, 4'b0010, 1, 'h11, 0, 1, 1));
    tbl.push_back(mk(0, 4'b0101, 4'b0101, 'h0, 'h20, 'h0, 'h02, 1, 4'b0100, 1, 'h12, 1, 1, 0));
    tbl.push_back(mk(0, 4'b0101, 4'b0101, 'h0, 'h20, 'h0, 'h02, 1, 4'b0001, 1, 'h20, 1, 2, 0));
    // Output stall for three cycles holding 0x55
    tbl.push_back(mk(1, 4'b0001, 4'b0001, 'h0, 'h0, 'h0, 'h55, 1, 4'b0001, 0, 'h0, 0, 0, 0));
    tbl.push_back(mk(0, 4'b0010, 4'b0010, 'h0, 'h0, 'h66, 'h0, 0, 4'b0000, 1, 'h55, 1, 0, 0));
    tbl.push_back(mk(0, 4'b0010, 4'b0010, 'h0, 'h0, 'h66, 'h0, 0, 4'b0000, 1, 'h55, 1, 0, 0));
    tbl.push_back(mk(0, 4'b0010, 4'b0010, 'h0, 'h0, 'h66, 'h0, 0, 4'b0000, 1, 'h55, 1, 0, 0));
    tbl.push_back(mk(0, 4'b0010, 4'b0010, 'h0, 'h0, 'h66, 'h0, 1, 4'b0010, 1, 'h55, 1, 0, 0));
    tbl.push_back(mk(0, 4'b0000, 4'b0000, 'h0, 'h0, 'h0, 'h0, 1, 4'b0000, 1, 'h66, 1, 1, 0));
    tbl.push_back(mk(0, 4'b0000, 4'b0000, 'h0, 'h0, 'h0, 'h0, 1, 4'b0000, 0, 'h0, 0, 0, 0));
    foreach (tbl[i]) apply(tbl[i], $sformatf("vec[%0d]", i));

    // Locked ch2 goes idle for two cycles while ch0 waits: bubble, lock held
    apply(mk(1, 4'b0100, 4'b0000, 'h0, 'h30, 'h0, 'h0, 1, 4'b0100, 0, 'h0, 0, 0, 0), "bubble0");
    apply(mk(0, 4'b0101, 4'b0001, 'h0, 'h31, 'h0, 'h0F, 1, 4'b0100, 1, 'h30, 0, 2, 1), "bubble1");
    apply(mk(0, 4'b0001, 4'b0001, 'h0, 'h0, 'h0, 'h0F, 1, 4'b0000, 1, 'h31, 0, 2, 1), "bubble2");
    apply(mk(0, 4'b0001, 4'b0001, 'h0, 'h0, 'h0, 'h0F, 1, 4'b0000, 0, 'h0, 0, 0, 1), "bubble3");
    apply(mk(0, 4'b0101, 4'b0101, 'h0, 'h32, 'h0, 'h0F, 1, 4'b0100, 0, 'h0, 0, 0, 1), "bubble4");
    apply(mk(0, 4'b0001, 4'b0001, 'h0, 'h0, 'h0, 'h0F, 1, 4'b0001, 1, 'h32, 1, 2, 0), "bubble5");

    // Asynchronous reset while locked with a beat on the output
    apply(mk(1, 4'b0100, 4'b0000, 'h0, 'h30, 'h0, 'h0, 1, 4'b0100, 0, 'h0, 0, 0, 0), "rstlk0");
    apply(mk(0, 4'b0101, 4'b0001, 'h0, 'h31, 'h0, 'h0F, 1, 4'b0100, 1, 'h30, 0, 2, 1), "rstlk1");
    #1 rst = 1'b1;
    #1;
    chk("rstlk.out_valid", 32'(out_valid), 32'h0);
    chk("rstlk.locked", 32'(locked), 32'h0);
    chk("rstlk.out_data", out_data, 32'h0);
    chk("rstlk.in_ready", 32'(in_ready), 32'h0);
    in_valid = 4'b1111;
    in_last  = 4'b1111;
    in_data  = {32'hD3, 32'hD2, 32'hD1, 32'hD0};
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rstlk.first_grant", 32'(in_ready), 32'h1);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("rstlk.first_sel", 32'(out_sel), 32'h0);
    chk("rstlk.first_data", out_data, 32'hD0);

    // Fixed priority: ch1 always beats ch3
    do_reset();
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      f_in_valid   = 4'b1010;
      f_in_last    = 4'b1010;
      f_in_data[1] = 32'h100 + 32'(i);
      f_in_data[3] = 32'h300;
      f_out_ready  = 1'b1;
      @(negedge clk);
      chk($sformatf("fixed[%0d].in_ready", i), 32'(f_in_ready), 32'h2);
      if (i > 0) begin
        chk($sformatf("fixed[%0d].out_sel", i), 32'(f_out_sel), 32'h1);
        chk($sformatf("fixed[%0d].out_data", i), f_out_data, 32'h100 + 32'(i - 1));
      end
    end

    run_random(3000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
